helix_reactor_mc: RTL and testbench

Multi-lane, parametrised successor to the single-channel helix reactor. Accepts a stream of context beats tagged with a lane ID. Each lane folds its beats into its own accumulator under a latched precision mode. A completed thought, meaning the fold *including* its final beat, is pushed into a shared output FIFO. Sits between the context fabric and the thought consumer in the helix datapath.

---
 rtl/helix_pkg.sv | 63 ++++++
 rtl/helix_thought_fifo.sv | 56 +++++
 rtl/helix_reactor_mc.sv | 138 +++++++++++++
 tb/tb_helix_reactor_mc.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/helix_pkg.sv
// Shared types, defaults and the lane fold function for the helix reactor family.
package helix_pkg;

  localparam int unsigned CONTEXT_W     = 8;
  localparam int unsigned THOUGHT_W     = 32;
  localparam int unsigned NUM_LANES_DEF = 4;
  localparam int unsigned BEATS_MAX_DEF = 8;
  // Widest accumulator the fold function supports.
  localparam int unsigned FOLD_MAX_W    = 128;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_XOR   = 2'b10,
    MODE_ADD   = 2'b11
  } reactor_mode_e;

  function automatic int unsigned lane_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_LANE_W = lane_w(NUM_LANES_DEF);
  localparam int unsigned DEF_BEAT_W = $clog2(BEATS_MAX_DEF + 1);

  typedef struct packed {
    logic [THOUGHT_W-1:0]  data;
    logic [DEF_LANE_W-1:0] lane;
    logic [DEF_BEAT_W-1:0] beats;
    logic                  ovf;
  } thought_entry_t;

  // One fold step at runtime widths cw/tw (callers pass their parameters).
  // Result layout is {acc, carry}: the low tw+1 bits hold the masked
  // accumulator above the ADD carry-out, so callers truncate to THOUGHT_W+1.
  function automatic logic [FOLD_MAX_W:0] helix_fold(
    input reactor_mode_e           mode,
    input logic [FOLD_MAX_W-1:0]   acc,
    input logic [FOLD_MAX_W-1:0]   ctx,
    input int unsigned             k,
    input int unsigned             cw,
    input int unsigned             tw
  );
    logic [FOLD_MAX_W-1:0] mask;
    logic [FOLD_MAX_W-1:0] res;
    logic [FOLD_MAX_W:0]   sum;
    logic                  carry;
    mask  = ~({FOLD_MAX_W{1'b1}} << tw);
    sum   = {1'b0, acc} + {1'b0, ctx};
    carry = 1'b0;
    case (mode)
      MODE_LOAD:  res = ctx;
      MODE_SHIFT: res = (acc << cw) | ctx;
      MODE_XOR:   res = acc ^ (ctx << (k * cw));
      MODE_ADD: begin
        res   = sum[FOLD_MAX_W-1:0];
        carry = sum[tw];
      end
      default:    res = acc;
    endcase
    return {res & mask, carry};
  endfunction

endpackage

// File: rtl/helix_thought_fifo.sv
// Show-ahead FIFO of thought entries with an occupancy count.
module helix_thought_fifo
  import helix_pkg::*;
#(
  parameter type         entry_t = thought_entry_t,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             head_ready,
  output logic             head_valid,
  output entry_t           head_data,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Handshake qualification and show-ahead head (zero while empty).
  always_comb begin
    head_valid = (count != '0);
    do_pop     = head_valid & head_ready;
    do_push    = push & (count < CNT_W'(DEPTH));
    head_data  = head_valid ? mem[rd_ptr] : '0;
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/helix_reactor_mc.sv
// Multi-lane helix reactor: folds lane-tagged context beats into per-lane
// accumulators and queues each completed thought into a shared FIFO.
module helix_reactor_mc
  import helix_pkg::*;
#(
  parameter int unsigned  CONTEXT_W = helix_pkg::CONTEXT_W,
  parameter int unsigned  THOUGHT_W = helix_pkg::THOUGHT_W,
  parameter int unsigned  NUM_LANES = NUM_LANES_DEF,
  parameter int unsigned  BEATS_MAX = BEATS_MAX_DEF,
  parameter int unsigned  OUT_DEPTH = 4,
  localparam int unsigned LANE_W    = lane_w(NUM_LANES),
  localparam int unsigned BEAT_W    = $clog2(BEATS_MAX + 1),
  localparam int unsigned CNT_W     = $clog2(OUT_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctx_valid,
  output logic                 ctx_ready,
  input  logic [CONTEXT_W-1:0] ctx_data,
  input  logic [LANE_W-1:0]    ctx_lane,
  input  logic                 ctx_last,
  input  logic [1:0]           precision_mode,
  input  logic                 flush,
  output logic                 thought_valid,
  input  logic                 thought_ready,
  output logic [THOUGHT_W-1:0] thought_data,
  output logic [LANE_W-1:0]    thought_lane,
  output logic [BEAT_W-1:0]    thought_beats,
  output logic                 thought_ovf,
  output logic [CNT_W-1:0]     fifo_count
);

  localparam int unsigned RATIO = THOUGHT_W / CONTEXT_W;

  // Lane FSM encoding; the state itself is implied by beat_cnt == 0.
  localparam logic [0:0] LANE_IDLE  = 1'b0;
  localparam logic [0:0] LANE_ACCUM = 1'b1;

  typedef struct packed {
    logic [THOUGHT_W-1:0] data;
    logic [LANE_W-1:0]    lane;
    logic [BEAT_W-1:0]    beats;
    logic                 ovf;
  } entry_t;

  logic [THOUGHT_W-1:0] acc_q  [NUM_LANES];
  logic [BEAT_W-1:0]    cnt_q  [NUM_LANES];
  reactor_mode_e        mode_q [NUM_LANES];
  logic                 ovf_q  [NUM_LANES];
  logic                 ready_en_q;

  logic [0:0]           lane_st;
  reactor_mode_e        eff_mode;
  logic [THOUGHT_W-1:0] op_acc;
  logic                 op_ovf;
  int unsigned          k;
  logic [THOUGHT_W:0]   fold_out;
  logic [THOUGHT_W-1:0] new_acc;
  logic                 new_ovf;
  logic [BEAT_W-1:0]    new_cnt;
  logic                 emit;
  logic                 beat_fire;
  entry_t               push_entry;
  entry_t               head;

  // Fold of the addressed lane with the incoming beat; an IDLE lane starts
  // from a zero operand and takes the freshly offered mode.
  always_comb begin
    lane_st   = (cnt_q[ctx_lane] == '0) ? LANE_IDLE : LANE_ACCUM;
    eff_mode  = (lane_st == LANE_IDLE) ? reactor_mode_e'(precision_mode) : mode_q[ctx_lane];
    op_acc    = (lane_st == LANE_IDLE) ? '0 : acc_q[ctx_lane];
    op_ovf    = (lane_st == LANE_IDLE) ? 1'b0 : ovf_q[ctx_lane];
    k         = 32'(cnt_q[ctx_lane]) % RATIO;
    fold_out  = (THOUGHT_W + 1)'(helix_fold(eff_mode, FOLD_MAX_W'(op_acc), FOLD_MAX_W'(ctx_data),
                                            k, CONTEXT_W, THOUGHT_W));
    new_acc   = fold_out[THOUGHT_W:1];
    new_ovf   = op_ovf | fold_out[0];
    new_cnt   = cnt_q[ctx_lane] + BEAT_W'(1);
    emit      = (new_cnt == BEAT_W'(BEATS_MAX)) | ctx_last;
    ctx_ready = ready_en_q & (fifo_count < CNT_W'(OUT_DEPTH)) & ~flush;
    beat_fire = ctx_valid & ctx_ready;
    push_entry.data  = new_acc;
    push_entry.lane  = ctx_lane;
    push_entry.beats = new_cnt;
    push_entry.ovf   = new_ovf;
  end

  // Per-lane state update; an emitting beat returns its lane to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
        mode_q[i] <= MODE_LOAD;
        ovf_q[i]  <= 1'b0;
      end
    end else begin
      ready_en_q <= 1'b1;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        if (flush || (beat_fire && emit && ctx_lane == LANE_W'(i))) begin
          acc_q[i]  <= '0;
          cnt_q[i]  <= '0;
          mode_q[i] <= MODE_LOAD;
          ovf_q[i]  <= 1'b0;
        end else if (beat_fire && ctx_lane == LANE_W'(i)) begin
          acc_q[i]  <= new_acc;
          cnt_q[i]  <= new_cnt;
          mode_q[i] <= eff_mode;
          ovf_q[i]  <= new_ovf;
        end
      end
    end
  end

  helix_thought_fifo #(
    .entry_t (entry_t),
    .DEPTH   (OUT_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (beat_fire & emit),
    .push_data  (push_entry),
    .head_ready (thought_ready),
    .head_valid (thought_valid),
    .head_data  (head),
    .count      (fifo_count)
  );

  // Unpack the FIFO head onto the thought port.
  always_comb begin
    thought_data  = head.data;
    thought_lane  = head.lane;
    thought_beats = head.beats;
    thought_ovf   = head.ovf;
  end

endmodule

// File: tb/tb_helix_reactor_mc.sv
// Bench for helix_reactor_mc: abstract lane/FIFO model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_helix_reactor_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 8-bit beats, 32-bit thoughts, 4 lanes, BEATS_MAX=4, depth 4.
  logic        ctx_valid = 0, ctx_last = 0, flush = 0, thought_ready = 0;
  logic [7:0]  ctx_data = 0;
  logic [1:0]  ctx_lane = 0, precision_mode = 0;
  logic        ctx_ready, thought_valid, thought_ovf;
  logic [31:0] thought_data;
  logic [1:0]  thought_lane;
  logic [2:0]  thought_beats, fifo_count;

  helix_reactor_mc #(
    .NUM_LANES (4),
    .BEATS_MAX (4),
    .OUT_DEPTH (4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctx_valid(ctx_valid), .ctx_ready(ctx_ready),
    .ctx_data(ctx_data), .ctx_lane(ctx_lane), .ctx_last(ctx_last),
    .precision_mode(precision_mode), .flush(flush), .thought_valid(thought_valid),
    .thought_ready(thought_ready), .thought_data(thought_data), .thought_lane(thought_lane),
    .thought_beats(thought_beats), .thought_ovf(thought_ovf), .fifo_count(fifo_count)
  );

  // Small instance: 4-bit beats into 8-bit thoughts so ADD can overflow.
  logic        s_valid = 0, s_last = 0, s_flush = 0, s_tready = 0;
  logic [3:0]  s_data = 0;
  logic [0:0]  s_lane = 0;
  logic [1:0]  s_mode = 0;
  logic        s_ready, s_tvalid, s_tovf;
  logic [7:0]  s_tdata;
  logic [0:0]  s_tlane;
  logic [5:0]  s_tbeats;
  logic [1:0]  s_count;

  helix_reactor_mc #(
    .CONTEXT_W (4),
    .THOUGHT_W (8),
    .NUM_LANES (2),
    .BEATS_MAX (32),
    .OUT_DEPTH (2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .ctx_valid(s_valid), .ctx_ready(s_ready),
    .ctx_data(s_data), .ctx_lane(s_lane), .ctx_last(s_last),
    .precision_mode(s_mode), .flush(s_flush), .thought_valid(s_tvalid),
    .thought_ready(s_tready), .thought_data(s_tdata), .thought_lane(s_tlane),
    .thought_beats(s_tbeats), .thought_ovf(s_tovf), .fifo_count(s_count)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model of the main instance ----------------
  typedef struct {
    logic [31:0] d;
    int          lane;
    int          beats;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_acc [4];
  int          m_cnt [4];
  int          m_mode[4];
  logic        m_ovf [4];
  bit          m_rdy_en = 0;

  function automatic bit m_ready();
    return m_rdy_en && (q.size() < 4) && !flush;
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_mode[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_reset();
    q.delete();
    clear_lanes();
    m_rdy_en = 0;
  endtask

  // Applies one clock edge worth of spec behaviour to the model.
  task automatic model_step();
    bit          rdy, pop, first;
    int          l, md, n;
    logic [31:0] a;
    logic [32:0] s;
    logic        o;
    rdy = m_ready();
    pop = (q.size() > 0) && thought_ready;
    l   = int'(ctx_lane);
    if (pop) void'(q.pop_front());
    if (flush) clear_lanes();
    else if (ctx_valid && rdy) begin
      first = (m_cnt[l] == 0);
      md    = first ? int'(precision_mode) : m_mode[l];
      a     = first ? 32'h0 : m_acc[l];
      o     = first ? 1'b0 : m_ovf[l];
      case (md)
        0: a = {24'h0, ctx_data};
        1: a = {a[23:0], ctx_data};
        2: a = a ^ ({24'h0, ctx_data} << (8 * (m_cnt[l] % 4)));
        default: begin
          s = {1'b0, a} + {25'h0, ctx_data};
          o = o | s[32];
          a = s[31:0];
        end
      endcase
      n = m_cnt[l] + 1;
      if (n == 4 || ctx_last) begin
        q.push_back('{a, l, n, o});
        m_acc[l] = 0; m_cnt[l] = 0; m_mode[l] = 0; m_ovf[l] = 0;
      end else begin
        m_acc[l] = a; m_cnt[l] = n; m_mode[l] = md; m_ovf[l] = o;
      end
    end
    m_rdy_en = 1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ctx_ready", 64'(ctx_ready), 64'(m_ready()));
      chk("fifo_count", 64'(fifo_count), 64'(q.size()));
      chk("thought_valid", 64'(thought_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("head_data", 64'(thought_data), 64'(q[0].d));
        chk("head_lane", 64'(thought_lane), 64'(q[0].lane));
        chk("head_beats", 64'(thought_beats), 64'(q[0].beats));
        chk("head_ovf", 64'(thought_ovf), 64'(q[0].ovf));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic beat(input int lane, input int data, input int mode, input bit last);
    ctx_valid = 1; ctx_lane = 2'(lane); ctx_data = 8'(data);
    precision_mode = 2'(mode); ctx_last = last;
    cycle();
    ctx_valid = 0; ctx_last = 0;
  endtask

  task automatic pop_chk(input string name, input logic [31:0] d, input int lane,
                         input int beats, input bit ovf);
    chk({name, ".valid"}, 64'(thought_valid), 64'd1);
    chk({name, ".data"},  64'(thought_data), 64'(d));
    chk({name, ".lane"},  64'(thought_lane), 64'(lane));
    chk({name, ".beats"}, 64'(thought_beats), 64'(beats));
    chk({name, ".ovf"},   64'(thought_ovf), 64'(ovf));
    thought_ready = 1;
    cycle();
    thought_ready = 0;
  endtask

  task automatic s_beat(input int data, input int mode, input bit last);
    s_valid = 1; s_data = 4'(data); s_mode = 2'(mode); s_last = last;
    cycle();
    s_valid = 0; s_last = 0;
  endtask

  task automatic s_pop();
    s_tready = 1;
    cycle();
    s_tready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset values.
    repeat (2) @(posedge clk);
    #2;
    chk("rst.ctx_ready", 64'(ctx_ready), 0);
    chk("rst.thought_valid", 64'(thought_valid), 0);
    chk("rst.thought_data", 64'(thought_data), 0);
    chk("rst.thought_lane", 64'(thought_lane), 0);
    chk("rst.thought_beats", 64'(thought_beats), 0);
    chk("rst.thought_ovf", 64'(thought_ovf), 0);
    chk("rst.fifo_count", 64'(fifo_count), 0);
    rst_n = 1;
    cycle();
    chk("post_rst.ctx_ready", 64'(ctx_ready), 1);

    // ADD on lane 0: 1+2+3 with last on the third beat.
    beat(0, 1, 3, 0);
    beat(0, 2, 3, 0);
    chk("add.not_yet_valid", 64'(thought_valid), 0);
    beat(0, 3, 3, 1);
    pop_chk("add", 32'd6, 0, 3, 0);

    // SHIFT on lane 2.
    beat(2, 8'hAA, 1, 0);
    beat(2, 8'hBB, 1, 0);
    beat(2, 8'hCC, 1, 0);
    beat(2, 8'hDD, 1, 1);
    pop_chk("shift", 32'hAABBCCDD, 2, 4, 0);

    // XOR on lane 1, forced emission at BEATS_MAX.
    beat(1, 8'h01, 2, 0);
    beat(1, 8'h02, 2, 0);
    beat(1, 8'h03, 2, 0);
    beat(1, 8'h04, 2, 0);
    pop_chk("xor", 32'h04030201, 1, 4, 0);

    // Interleaved lanes; mode on L0's second beat must be ignored.
    beat(0, 5, 3, 0);
    beat(1, 9, 0, 1);
    beat(0, 7, 0, 1);
    pop_chk("il_l1", 32'd9, 1, 1, 0);
    pop_chk("il_l0", 32'd12, 0, 2, 0);

    // Fill the FIFO with the consumer stalled.
    for (int i = 0; i < 4; i++) beat(i, 8'h10 + i, 0, 1);
    chk("full.ctx_ready", 64'(ctx_ready), 0);
    chk("full.fifo_count", 64'(fifo_count), 4);
    chk("full.head", 64'(thought_data), 64'h10);
    // Blocked beat offered while one entry pops.
    ctx_valid = 1; ctx_lane = 0; ctx_data = 8'h55; precision_mode = 3; ctx_last = 0;
    thought_ready = 1;
    cycle();
    thought_ready = 0; ctx_valid = 0;
    chk("after_pop.ctx_ready", 64'(ctx_ready), 1);
    chk("after_pop.fifo_count", 64'(fifo_count), 3);
    pop_chk("order1", 32'h11, 1, 1, 0);
    pop_chk("order2", 32'h12, 2, 1, 0);
    pop_chk("order3", 32'h13, 3, 1, 0);

    // Flush mid-thought: next beat starts fresh with a re-latched mode.
    beat(3, 8'h20, 3, 0);
    flush = 1; ctx_valid = 1; ctx_lane = 3; ctx_data = 8'h99; precision_mode = 3;
    #1;
    chk("flush.ctx_ready", 64'(ctx_ready), 0);
    cycle();
    flush = 0; ctx_valid = 0;
    beat(3, 8'h07, 0, 1);
    pop_chk("flush", 32'h07, 3, 1, 0);

    // Small instance: all-ones + 2 wraps to 1 with carry-out.
    for (int i = 0; i < 17; i++) s_beat(4'hF, 3, 0);
    s_beat(2, 3, 1);
    chk("ovf.valid", 64'(s_tvalid), 1);
    chk("ovf.data", 64'(s_tdata), 64'h01);
    chk("ovf.beats", 64'(s_tbeats), 18);
    chk("ovf.ovf", 64'(s_tovf), 1);
    chk("ovf.lane", 64'(s_tlane), 0);
    s_pop();
    // Overflowed partial thought flushed; next beat is a fresh LOAD.
    for (int i = 0; i < 17; i++) s_beat(4'hF, 3, 0);
    s_beat(2, 3, 0);
    s_flush = 1;
    cycle();
    s_flush = 0;
    chk("sflush.count", 64'(s_count), 0);
    s_beat(5, 0, 1);
    chk("sflush.data", 64'(s_tdata), 64'h05);
    chk("sflush.beats", 64'(s_tbeats), 1);
    chk("sflush.ovf", 64'(s_tovf), 0);
    chk("sflush.count1", 64'(s_count), 1);
    s_pop();

    // Reset mid-thought discards partial lanes and queued thoughts.
    beat(0, 1, 3, 0);
    beat(1, 8'h42, 0, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("mid_rst.fifo_count", 64'(fifo_count), 0);
    chk("mid_rst.thought_valid", 64'(thought_valid), 0);
    chk("mid_rst.ctx_ready", 64'(ctx_ready), 0);
    @(posedge clk);
    #2;
    rst_n = 1;
    model_reset();
    cycle();
    cycle();
    beat(0, 3, 3, 1);
    pop_chk("post_rst_add", 32'd3, 0, 1, 0);

    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
